serial_to_parallel_4bit: RTL

Deserializer directly upstream of the 4-bit parallel register stage.
- Collects framed serial bits and assembles them into a WIDTH-bit word.
- Presents the word on data_out with a one-cycle word_valid strobe, so the downstream register captures it on the next clk edge.
- Detects broken frames and reports them.

---
 rtl/s2p_pkg.sv | 20 ++
 rtl/s2p_bit_counter.sv | 41 ++++
 rtl/serial_to_parallel_4bit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/s2p_pkg.sv
// Shared types and helpers for the serial-to-parallel deserializer.
// Holds the FSM state enum, default word width and parity helper.
package s2p_pkg;

   typedef enum logic {
      S_IDLE,
      S_SHIFT
   } s2p_state_e;

   localparam int S2P_DEF_WIDTH = 4;
   localparam int S2P_MAX_WIDTH = 32;

   // Zero-extended input: padding bits do not alter the parity.
   function automatic logic even_parity(
      input logic [S2P_MAX_WIDTH-1:0] word
   );
      return ^word;
   endfunction

endpackage

// File: rtl/s2p_bit_counter.sv
// Loadable saturating up-counter with clear, load-1 and a
// terminal-count flag that is high when the next bit ends the frame.
module s2p_bit_counter #(
   parameter int CW   = 3,
   parameter int TERM = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic load1,
   input  logic inc,
   output logic last
);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Clear wins over load-1, load-1 over increment; never wraps.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (load1) begin
         count_d = CW'(1);
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + CW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign last = (count_q == CW'(TERM - 1));

endmodule

// File: rtl/serial_to_parallel_4bit.sv
// Framed serial-to-parallel deserializer with abort detection.
// Define SERIAL_TO_PARALLEL_PARITY_EN for a trailing even-parity bit.
module serial_to_parallel_4bit
   import s2p_pkg::*;
#(
   parameter int WIDTH     = S2P_DEF_WIDTH,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             serial_in,
   input  logic             bit_valid,
   input  logic             frame_start,
   output logic [WIDTH-1:0] data_out,
   output logic             word_valid,
   output logic             busy,
   output logic             frame_err,
   output logic             parity_err
);

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
   localparam int FRAME_LEN = WIDTH + 1;
`else
   localparam int FRAME_LEN = WIDTH;
`endif
   localparam int CW = $clog2(WIDTH + 2);

   s2p_state_e       state_q;
   s2p_state_e       state_d;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] shift_d;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;
   logic             word_valid_q;
   logic             word_valid_d;
   logic             frame_err_q;
   logic             frame_err_d;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
   logic             parity_err_q;
   logic             parity_err_d;
   logic [S2P_MAX_WIDTH-1:0] par_word;
   logic             par_ok;
`endif

   logic cnt_clr;
   logic cnt_load1;
   logic cnt_inc;
   logic cnt_last;

   logic start;
   logic done;
   logic data_bit;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] fresh;

   function automatic logic [WIDTH-1:0] shift_in(
      input logic [WIDTH-1:0] base,
      input logic             b
   );
      if (MSB_FIRST != 0) begin
         return {base[WIDTH-2:0], b};
      end else begin
         return {b, base[WIDTH-1:1]};
      end
   endfunction

   s2p_bit_counter #(
      .CW   (CW),
      .TERM (FRAME_LEN)
   ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .load1 (cnt_load1),
      .inc   (cnt_inc),
      .last  (cnt_last)
   );

   assign start    = bit_valid & frame_start;
   assign done     = bit_valid & ~frame_start & cnt_last;
   assign data_bit = bit_valid & ~frame_start & ~cnt_last;
   assign shifted  = shift_in(shift_q, serial_in);
   assign fresh    = shift_in('0, serial_in);

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
   // Parity over the held data bits plus the incoming parity bit.
   always_comb begin
      par_word             = '0;
      par_word[WIDTH-1:0]  = shift_q;
      par_ok = ~(even_parity(par_word) ^ serial_in);
   end
`endif

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         shift_q      <= '0;
         data_q       <= '0;
         word_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         data_q       <= data_d;
         word_valid_q <= word_valid_d;
         frame_err_q  <= frame_err_d;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   // Next state: enter SHIFT on a frame start, leave on the last bit.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (done) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath, counter control and strobes for the current bit.
   always_comb begin
      shift_d      = shift_q;
      data_d       = data_q;
      word_valid_d = 1'b0;
      frame_err_d  = 1'b0;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
      parity_err_d = 1'b0;
`endif
      cnt_clr      = 1'b0;
      cnt_load1    = 1'b0;
      cnt_inc      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               shift_d   = fresh;
               cnt_load1 = 1'b1;
            end
         end
         S_SHIFT: begin
            unique case (1'b1)
               start: begin
                  frame_err_d = 1'b1;
                  shift_d     = fresh;
                  cnt_load1   = 1'b1;
               end
               done: begin
                  cnt_clr = 1'b1;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
                  if (par_ok) begin
                     data_d       = shift_q;
                     word_valid_d = 1'b1;
                  end else begin
                     parity_err_d = 1'b1;
                  end
`else
                  data_d       = shifted;
                  word_valid_d = 1'b1;
`endif
               end
               data_bit: begin
                  shift_d = shifted;
                  cnt_inc = 1'b1;
               end
               default: begin
               end
            endcase
         end
         default: begin
         end
      endcase
   end

   assign data_out   = data_q;
   assign word_valid = word_valid_q;
   assign frame_err  = frame_err_q;
   assign busy       = (state_q == S_SHIFT);
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule
